// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, NOP constant and default field widths for pipeline stage registers
package pipe_pkg;
   typedef enum logic [1:0] {EMPTY, BUSY, FULL} pipe_state_t;
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_W_DEF = 32;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: load/clear data register with valid; ports clk_i, rst_i, clr_i (to CLR_VAL, invalid), ld_i, d_i -> q_o, v_o
module pipe_entry #(
   parameter int W = 1,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic         v_o
);
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         q_o <= CLR_VAL;
         v_o <= 1'b0;
      end else if (ld_i) begin
         q_o <= d_i;
         v_o <= 1'b1;
      end
   end
endmodule

// File: rtl/if_id_skid_register.sv
// if_id_skid_register: IF/ID stage with valid/ready, 2-entry skid buffer, flush; ports clk_i, rst_i, flush_i, in_valid_i/in_ready_o/instruction_i/pc_result_i upstream, out_valid_o/out_ready_i/instruction_o/pc_result_o downstream
module if_id_skid_register
   import pipe_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_W = PC_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(MIPS_NOP)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [INSTR_W-1:0] instruction_i,
   input  logic [PC_W-1:0]    pc_result_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [INSTR_W-1:0] instruction_o,
   output logic [PC_W-1:0]    pc_result_o
);
   localparam int W = INSTR_W + PC_W;
   pipe_state_t state_q, state_d;
   logic in_ready_q, in_fire, out_fire, kill;
   logic main_ld, main_clr, skid_ld, skid_clr, main_v, skid_v;
   logic [W-1:0] main_q, main_d, skid_q;
   assign kill = rst_i | flush_i;
   assign in_fire = in_valid_i & in_ready_q;
   assign out_fire = main_v & out_ready_i;
   always_comb begin
      state_d = kill ? EMPTY :
                state_q == EMPTY ? (in_fire ? BUSY : EMPTY) :
                state_q == BUSY ? ((in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : BUSY) :
                (out_fire ? BUSY : FULL);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         in_ready_q <= state_d != FULL;
      end
   end
   // Main refills from skid when FULL drains, otherwise straight from fetch.
   assign main_d = state_q == FULL ? skid_q : {instruction_i, pc_result_i};
   assign main_ld = ~kill & ((in_fire & (state_q == EMPTY | out_fire)) | (state_q == FULL & out_fire));
   assign main_clr = flush_i | (state_q == BUSY & out_fire & ~in_fire);
   assign skid_ld = ~kill & state_q == BUSY & in_fire & ~out_fire;
   assign skid_clr = flush_i | (state_q == FULL & out_fire);
   pipe_entry #(.W(W), .CLR_VAL({NOP_INSTR, {PC_W{1'b0}}})) u_main (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(main_clr), .ld_i(main_ld),
      .d_i(main_d), .q_o(main_q), .v_o(main_v)
   );
   pipe_entry #(.W(W), .CLR_VAL('0)) u_skid (
      .clk_i(clk_i), .rst_i(rst_i), .clr_i(skid_clr), .ld_i(skid_ld),
      .d_i({instruction_i, pc_result_i}), .q_o(skid_q), .v_o(skid_v)
   );
   // The skid entry is occupied exactly in FULL.
   a_skid_full: assert property (@(posedge clk_i) disable iff (rst_i) skid_v == (state_q == FULL));
   assign in_ready_o = in_ready_q;
   assign out_valid_o = main_v;
   assign {instruction_o, pc_result_o} = main_q;
endmodule

// File: tb/tb_if_id_skid_register.sv
// tb_if_id_skid_register: directed and randomized checks of the IF/ID skid stage against a queue model
module tb_if_id_skid_register;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] instr_in = '0, pc_in = '0;
   logic in_ready, out_valid;
   logic [31:0] instr_out, pc_out;
   logic s_rst = 1'b1, s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
   logic [15:0] s_instr_in = '0, s_instr_out;
   logic [7:0] s_pc_in = '0, s_pc_out;
   logic s_in_ready, s_out_valid;
   int total = 0, passed = 0;
   logic [63:0] mq[$];

   if_id_skid_register dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instruction_i(instr_in), .pc_result_i(pc_in), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .instruction_o(instr_out), .pc_result_o(pc_out)
   );
   if_id_skid_register #(.INSTR_W(16), .PC_W(8), .NOP_INSTR(16'hFFFF)) dut_s (
      .clk_i(clk), .rst_i(s_rst), .flush_i(s_flush), .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
      .instruction_i(s_instr_in), .pc_result_i(s_pc_in), .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
      .instruction_o(s_instr_out), .pc_result_o(s_pc_out)
   );

   // Model: the stage is a FIFO of capacity 2; ready whenever it holds fewer than 2 words.
   task automatic tick();
      bit of, inf;
      of = (mq.size() > 0) && out_ready;
      inf = in_valid && (mq.size() < 2);
      @(posedge clk);
      if (rst || flush) mq.delete();
      else begin
         if (of) void'(mq.pop_front());
         if (inf) mq.push_back({instr_in, pc_in});
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready); else passed++;
      total++; if (instr_out !== 32'h0) $display("FAIL reset_instr got %h want 0", instr_out); else passed++;
      total++; if (pc_out !== 32'h0) $display("FAIL reset_pc got %h want 0", pc_out); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] w[3] = '{32'h20080005, 32'h20090003, 32'h01095020};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; instr_in = w[i]; pc_in = 32'(4 * (i + 1));
         tick();
         total++; if (out_valid !== 1'b1 || instr_out !== w[i] || pc_out !== 32'(4 * (i + 1)))
            $display("FAIL b2b_word%0d got v=%b %h/%h want 1 %h/%h", i, out_valid, instr_out, pc_out, w[i], 4 * (i + 1));
         else passed++;
         total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); else passed++;
      end
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0 || instr_out !== 32'h0) $display("FAIL b2b_drain got v=%b %h want 0 00000000", out_valid, instr_out); else passed++;
   endtask

   task automatic test_stall();
      out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hAAAA0001; pc_in = 32'h20;
      tick();
      total++; if (instr_out !== 32'hAAAA0001 || in_ready !== 1'b1) $display("FAIL stall_first got %h r=%b want aaaa0001 r=1", instr_out, in_ready); else passed++;
      instr_in = 32'hAAAA0002; pc_in = 32'h24;
      tick();
      in_valid = 1'b0;
      total++; if (instr_out !== 32'hAAAA0001 || in_ready !== 1'b0) $display("FAIL stall_full got %h r=%b want aaaa0001 r=0", instr_out, in_ready); else passed++;
      tick();
      total++; if (instr_out !== 32'hAAAA0001 || pc_out !== 32'h20 || out_valid !== 1'b1) $display("FAIL stall_hold got %h/%h v=%b want aaaa0001/00000020 v=1", instr_out, pc_out, out_valid); else passed++;
      out_ready = 1'b1;
      tick();
      total++; if (instr_out !== 32'hAAAA0002 || pc_out !== 32'h24 || out_valid !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL stall_second got %h/%h v=%b r=%b want aaaa0002/00000024 v=1 r=1", instr_out, pc_out, out_valid, in_ready);
      else passed++;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL stall_empty got %b want 0", out_valid); else passed++;
   endtask

   task automatic test_flush_full();
      out_ready = 1'b0; in_valid = 1'b1;
      instr_in = 32'hB0000001; pc_in = 32'h30; tick();
      instr_in = 32'hB0000002; pc_in = 32'h34; tick();
      total++; if (in_ready !== 1'b0) $display("FAIL flush_prefull got %b want 0", in_ready); else passed++;
      flush = 1'b1; instr_in = 32'hDEAD0000; pc_in = 32'h38; out_ready = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0 || in_ready !== 1'b1)
         $display("FAIL flush_state got v=%b %h/%h r=%b want v=0 0/0 r=1", out_valid, instr_out, pc_out, in_ready);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0 || instr_out === 32'hDEAD0000) $display("FAIL flush_leak got v=%b %h want v=0 not dead0000", out_valid, instr_out); else passed++;
      end
   endtask

   task automatic test_reset_flush();
      out_ready = 1'b0; in_valid = 1'b1; instr_in = 32'hC0000001; pc_in = 32'h40;
      tick();
      rst = 1'b1; flush = 1'b1; instr_in = 32'hC0000002; pc_in = 32'h44;
      tick();
      rst = 1'b0; flush = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 32'h0 || pc_out !== 32'h0)
         $display("FAIL rstflush got v=%b r=%b %h/%h want v=0 r=1 0/0", out_valid, in_ready, instr_out, pc_out);
      else passed++;
      instr_in = 32'h8C0A0004; pc_in = 32'h10; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || instr_out !== 32'h8C0A0004 || pc_out !== 32'h10)
         $display("FAIL rstflush_next got v=%b %h/%h want 1 8c0a0004/00000010", out_valid, instr_out, pc_out);
      else passed++;
      tick();
   endtask

   task automatic test_random();
      logic [31:0] seq = 32'h1000;
      logic pv = 1'b0, pr = 1'b1, pf = 1'b0;
      logic [63:0] po = '0;
      bit acc;
      for (int c = 0; c < 10000; c++) begin
         if (!in_valid || acc) begin
            in_valid = ($urandom % 4) != 0;
            seq++; instr_in = seq; pc_in = $urandom;
         end
         out_ready = ($urandom % 3) != 0;
         flush = ($urandom % 97) == 0;
         acc = in_valid && (mq.size() < 2) && !flush;
         pv = out_valid; pr = out_ready; pf = flush; po = {instr_out, pc_out};
         tick();
         total++; if (out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, mq.size() > 0); else passed++;
         total++; if (in_ready !== (mq.size() < 2)) $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, mq.size() < 2); else passed++;
         total++; if ({instr_out, pc_out} !== (mq.size() > 0 ? mq[0] : 64'h0)) $display("FAIL rnd_data c=%0d got %h want %h", c, {instr_out, pc_out}, mq.size() > 0 ? mq[0] : 64'h0); else passed++;
         if (pv && !pr && !pf) begin
            total++; if ({instr_out, pc_out} !== po) $display("FAIL rnd_stable c=%0d got %h want %h", c, {instr_out, pc_out}, po); else passed++;
         end
      end
      in_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic test_param_sweep();
      s_rst = 1'b1; @(posedge clk); #1; s_rst = 1'b0;
      total++; if (s_instr_out !== 16'hFFFF || s_pc_out !== 8'h0 || s_out_valid !== 1'b0) $display("FAIL sweep_reset got %h/%h v=%b want ffff/00 v=0", s_instr_out, s_pc_out, s_out_valid); else passed++;
      s_in_valid = 1'b1; s_instr_in = 16'h1234; s_pc_in = 8'h7F; s_out_ready = 1'b1;
      @(posedge clk); #1; s_in_valid = 1'b0;
      total++; if (s_instr_out !== 16'h1234 || s_pc_out !== 8'h7F || s_out_valid !== 1'b1) $display("FAIL sweep_data got %h/%h v=%b want 1234/7f v=1", s_instr_out, s_pc_out, s_out_valid); else passed++;
      @(posedge clk); #1;
      total++; if (s_instr_out !== 16'hFFFF || s_pc_out !== 8'h0 || s_out_valid !== 1'b0) $display("FAIL sweep_empty got %h/%h v=%b want ffff/00 v=0", s_instr_out, s_pc_out, s_out_valid); else passed++;
      s_in_valid = 1'b1; s_instr_in = 16'h5678; s_pc_in = 8'h11; s_out_ready = 1'b0;
      @(posedge clk); #1; s_in_valid = 1'b0; s_flush = 1'b1;
      @(posedge clk); #1; s_flush = 1'b0;
      total++; if (s_instr_out !== 16'hFFFF || s_pc_out !== 8'h0 || s_out_valid !== 1'b0 || s_in_ready !== 1'b1)
         $display("FAIL sweep_flush got %h/%h v=%b r=%b want ffff/00 v=0 r=1", s_instr_out, s_pc_out, s_out_valid, s_in_ready);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush_full();
      test_reset_flush();
      test_random();
      test_param_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/if_id_skid_register.md
Name: if_id_skid_register

Overview:
- Parametrised successor to the plain IF/ID pipeline latch: a 1-cycle pipeline stage between fetch and decode.
- Adds a valid/ready handshake with a 2-entry skid buffer, so the upstream ready is registered and throughput is still 1/cycle.
- Adds a synchronous flush for branch/jump squash.
- Flushed or empty slots present a NOP instruction downstream.

Parameters:
- INSTR_W, 32, instruction field width.
- PC_W, 32, PC-result field width.
- NOP_INSTR, 32'h0000_0000, instruction presented when the stage holds no valid entry; width INSTR_W.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous reset, active-high.
- Flush  in  1  squash all held entries this cycle.
- InValid  in  1  upstream has an instruction.
- InReady  out  1  stage accepts input this cycle; registered output.
- InstructionIn  in  INSTR_W  fetched instruction.
- PCResultIn  in  PC_W  PC+4 from fetch.
- OutValid  out  1  InstructionOut/PCResultOut are valid.
- OutReady  in  1  decode consumes this cycle.
- InstructionOut  out  INSTR_W  instruction to decode.
- PCResultOut  out  PC_W  PC+4 to decode.

Behaviour:
- Storage: main entry (drives outputs directly from flops) and skid entry.
- Handshake events: in_fire = InValid & InReady; out_fire = OutValid & OutReady.
- States:
  - EMPTY: neither entry valid.
  - BUSY: main entry valid.
  - FULL: main and skid entries valid.
- OutValid = (state != EMPTY).
- InReady is a flop equal to (next_state != FULL); it is 0 exactly while in FULL.
- Transitions (when neither Reset nor Flush is asserted):
  - EMPTY, in_fire: main <= input; go to BUSY.
  - BUSY, in_fire & out_fire: main <= input; stay BUSY.
  - BUSY, in_fire & !out_fire: skid <= input; go to FULL.
  - BUSY, !in_fire & out_fire: go to EMPTY; main data -> NOP_INSTR / PC 0.
  - FULL: no in_fire is possible. On out_fire, main <= skid and go to BUSY. Otherwise hold.
- Latency: data accepted at edge N is visible on the outputs after edge N (1 cycle) when the stage was EMPTY, or when it was BUSY with out_fire.
- Stability: while OutValid & !OutReady, InstructionOut and PCResultOut must not change.
- Flush (Reset = 0):
  - Next state EMPTY; both entries dropped.
  - Any in_fire in the same cycle is discarded.
  - Outputs: InstructionOut = NOP_INSTR, PCResultOut = 0, OutValid = 0, InReady = 1 after the edge.
  - A same-cycle out_fire still counts as consumed by decode; no replay.
- Reset has priority over Flush. Reset values: state EMPTY, OutValid 0, InReady 1, InstructionOut NOP_INSTR, PCResultOut 0, skid contents 0.
- Reset mid-operation (FULL or BUSY) discards all entries, same as reset from idle.
- InValid must be held by upstream until in_fire; no data-change check is made inside the stage.
- No arithmetic; fields pass through unmodified with widths exactly as the parameters give.

Decomposition:
- Shared package pipe_pkg:
  - enum pipe_state_t {EMPTY, BUSY, FULL}.
  - Constant MIPS_NOP = 32'h0000_0000.
  - Default widths INSTR_W_DEF = 32 and PC_W_DEF = 32, reused by later ID/EX, EX/MEM and MEM/WB stages.
- One sub-module is natural: pipe_entry, a width-parametrised load/clear register with data and valid. It is instantiated twice (main, skid).
- The FSM and handshake logic stay in the top.

Test Plan:
- Reset, then 3 back-to-back words (Instr 0x20080005/0x20090003/0x01095020, PC 0x4/0x8/0xC) with OutReady = 1 -> each appears 1 cycle later; InReady stays 1; OutValid is high for 3 consecutive cycles.
- Stall: OutReady = 0 while 2 words are sent (0xAAAA0001 then 0xAAAA0002) -> outputs hold 0xAAAA0001; InReady drops to 0 the cycle after the 2nd accept; on OutReady = 1, 0xAAAA0001 then 0xAAAA0002 come out in order with no loss or duplicate.
- Flush in FULL, with an InValid word 0xDEAD0000 offered the same cycle -> next cycle OutValid = 0, InstructionOut = 0x00000000, PCResultOut = 0, InReady = 1; 0xDEAD0000 never appears.
- Reset and Flush asserted together in BUSY -> reset values exactly; next word 0x8C0A0004 at PC 0x10 passes with 1-cycle latency.
- Random InValid/OutReady (≥10k cycles) against a scoreboard FIFO -> order preserved, no drops or duplicates, outputs stable while stalled, InReady never 1 in FULL.
- Parameter sweep INSTR_W = 16, PC_W = 8, NOP_INSTR = 16'hFFFF -> empty/flush present 0xFFFF; data 0x1234 / PC 0x7F passes through unmodified.
